// File: rtl/moore_seq_detector.sv
// Parametrised Moore sequence detector with failure-function fallback and saturating match counter.
// Optional build macro MOORE_SD_PROG_PAT_EN adds a run-time loadable pattern (pat_load / pat_in).
module moore_seq_detector #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
   parameter int               CNT_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         x,
   input  logic                         overlap,
   input  logic                         clr_cnt,
`ifdef MOORE_SD_PROG_PAT_EN
   input  logic                         pat_load,
   input  logic [PAT_W-1:0]             pat_in,
`endif
   output logic                         y,
   output logic [CNT_W-1:0]             match_cnt,
   output logic [$clog2(PAT_W+1)-1:0]   state_o
);

   localparam int SW = $clog2(PAT_W + 1);
   typedef logic [SW-1:0] state_t;
   localparam state_t S0      = '0;
   localparam state_t S_MATCH = state_t'(PAT_W);

   state_t             state_q, state_d, nxt;
   state_t             fill_q, fill_d, nf;
   logic [PAT_W-2:0]   hist_q, hist_d;
   logic [PAT_W-1:0]   nh;
   logic [PAT_W-1:0]   pat;
   logic               accept;

`ifdef MOORE_SD_PROG_PAT_EN
   logic [PAT_W-1:0]   pat_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          pat_q <= PATTERN;
      else if (pat_load) pat_q <= pat_in;
   end

   assign pat    = pat_q;
   assign accept = en && !pat_load;
`else
   assign pat    = PATTERN;
   assign accept = en;
`endif

   // nh is the history including the incoming bit; nf counts how many of its bits are real.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves a latch.
      hist_d  = hist_q;
      fill_d  = fill_q;
      state_d = state_q;
      nxt     = S0;
      if (state_q == S_MATCH && !overlap) begin
         nh = {{(PAT_W-1){1'b0}}, x};
         nf = state_t'(1);
      end else begin
         nh = {hist_q, x};
         nf = (fill_q == S_MATCH) ? fill_q : fill_q + 1'b1;
      end
      // Longest prefix of the pattern that is a suffix of the real history bits.
      for (int j = 1; j <= PAT_W; j++) begin
         if (j <= int'(nf) &&
             (({PAT_W{1'b1}} >> (PAT_W - j)) & (nh ^ (pat >> (PAT_W - j)))) == '0)
            nxt = state_t'(j);
      end
      if (accept) begin
         hist_d  = nh[PAT_W-2:0];
         fill_d  = nf;
         state_d = nxt;
      end
`ifdef MOORE_SD_PROG_PAT_EN
      if (pat_load) begin
         hist_d  = '0;
         fill_d  = S0;
         state_d = S0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S0;
         fill_q  <= S0;
         hist_q  <= '0;
         y       <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         state_q <= state_d;
         fill_q  <= fill_d;
         hist_q  <= hist_d;
         y       <= (state_d == S_MATCH);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         match_cnt <= '0;
      else if (clr_cnt)
         match_cnt <= '0;
      else if (accept && state_d == S_MATCH && match_cnt != '1)
         match_cnt <= match_cnt + 1'b1;
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed self-checking bench for moore_seq_detector: default instance plus a CNT_W=2 instance.
module tb_moore_seq_detector;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       x = 1'b0;
   logic       overlap = 1'b1;
   logic       clr_cnt = 1'b0;
   logic       y, y2;
   logic [7:0] cnt;
   logic [1:0] cnt2;
   logic [2:0] st, st2;
   int         vectors = 0;
   int         miscompares = 0;

   always #5 clk = ~clk;

   moore_seq_detector dut (
      .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .clr_cnt(clr_cnt),
`ifdef MOORE_SD_PROG_PAT_EN
      .pat_load(1'b0), .pat_in(4'b1011),
`endif
      .y(y), .match_cnt(cnt), .state_o(st)
   );

   moore_seq_detector #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .clr_cnt(clr_cnt),
`ifdef MOORE_SD_PROG_PAT_EN
      .pat_load(1'b0), .pat_in(4'b1011),
`endif
      .y(y2), .match_cnt(cnt2), .state_o(st2)
   );

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; en = 1'b0; clr_cnt = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic apply_bit(input logic b, input logic clr);
      @(negedge clk);
      en = 1'b1; x = b; clr_cnt = clr;
      @(posedge clk);
      #1;
      en = 1'b0; clr_cnt = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++;
      if (y !== 1'b0 || cnt !== 8'd0 || st !== 3'd0) begin
         miscompares++;
         $display("FAIL reset: y=%b cnt=%0d st=%0d expected 0/0/0", y, cnt, st);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_overlap();
      int bits [7]   = '{1, 0, 1, 1, 0, 1, 1};
      int exp_st [7] = '{1, 2, 3, 4, 2, 3, 4};
      do_reset();
      overlap = 1'b1;
      for (int i = 0; i < 7; i++) begin
         apply_bit(bits[i] != 0, 1'b0);
         vectors++;
         if (st !== 3'(exp_st[i]) || y !== (exp_st[i] == 4)) begin
            miscompares++;
            $display("FAIL overlap bit%0d: st=%0d y=%b expected st=%0d y=%b",
                     i + 1, st, y, exp_st[i], exp_st[i] == 4);
         end
      end
      vectors++;
      if (cnt !== 8'd2) begin
         miscompares++;
         $display("FAIL overlap count: got %0d expected 2", cnt);
      end
   endtask

   task automatic test_nonoverlap();
      int bits [11]   = '{1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1};
      int exp_st [11] = '{1, 2, 3, 4, 0, 1, 1, 1, 2, 3, 4};
      do_reset();
      overlap = 1'b0;
      for (int i = 0; i < 11; i++) begin
         apply_bit(bits[i] != 0, 1'b0);
         vectors++;
         if (st !== 3'(exp_st[i]) || y !== (exp_st[i] == 4)) begin
            miscompares++;
            $display("FAIL nonoverlap bit%0d: st=%0d y=%b expected st=%0d y=%b",
                     i + 1, st, y, exp_st[i], exp_st[i] == 4);
         end
         if (i == 6) begin
            vectors++;
            if (cnt !== 8'd1) begin
               miscompares++;
               $display("FAIL nonoverlap count1: got %0d expected 1", cnt);
            end
         end
      end
      vectors++;
      if (cnt !== 8'd2) begin
         miscompares++;
         $display("FAIL nonoverlap count2: got %0d expected 2", cnt);
      end
      overlap = 1'b1;
   endtask

   task automatic test_fallback();
      int bits [6]   = '{1, 0, 1, 0, 1, 1};
      int exp_st [6] = '{1, 2, 3, 2, 3, 4};
      do_reset();
      overlap = 1'b1;
      for (int i = 0; i < 6; i++) begin
         apply_bit(bits[i] != 0, 1'b0);
         vectors++;
         if (st !== 3'(exp_st[i]) || y !== (exp_st[i] == 4)) begin
            miscompares++;
            $display("FAIL fallback bit%0d: st=%0d y=%b expected st=%0d y=%b",
                     i + 1, st, y, exp_st[i], exp_st[i] == 4);
         end
      end
      vectors++;
      if (cnt !== 8'd1) begin
         miscompares++;
         $display("FAIL fallback count: got %0d expected 1", cnt);
      end
   endtask

   task automatic test_enable();
      int bits [4]   = '{1, 0, 1, 1};
      int exp_st [4] = '{1, 2, 3, 4};
      do_reset();
      overlap = 1'b1;
      for (int i = 0; i < 4; i++) begin
         apply_bit(bits[i] != 0, 1'b0);
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            en = 1'b0; x = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            vectors++;
            if (st !== 3'(exp_st[i]) || y !== (exp_st[i] == 4)) begin
               miscompares++;
               $display("FAIL enable hold bit%0d idle%0d: st=%0d y=%b expected st=%0d y=%b",
                        i + 1, k, st, y, exp_st[i], exp_st[i] == 4);
            end
         end
      end
      vectors++;
      if (cnt !== 8'd1) begin
         miscompares++;
         $display("FAIL enable count: got %0d expected 1", cnt);
      end
   endtask

   task automatic test_async_reset();
      int bits [7] = '{1, 0, 1, 1, 1, 0, 1};
      do_reset();
      overlap = 1'b1;
      for (int i = 0; i < 7; i++) apply_bit(bits[i] != 0, 1'b0);
      vectors++;
      if (st !== 3'd3 || cnt !== 8'd1) begin
         miscompares++;
         $display("FAIL async pre: st=%0d cnt=%0d expected 3/1", st, cnt);
      end
      #2;
      rst = 1'b0;
      #1;
      vectors++;
      if (y !== 1'b0 || cnt !== 8'd0 || st !== 3'd0) begin
         miscompares++;
         $display("FAIL async reset: y=%b cnt=%0d st=%0d expected 0/0/0", y, cnt, st);
      end
      @(negedge clk);
      rst = 1'b1;
      apply_bit(1'b1, 1'b0);
      apply_bit(1'b0, 1'b0);
      apply_bit(1'b1, 1'b0);
      apply_bit(1'b1, 1'b0);
      vectors++;
      if (y !== 1'b1 || cnt !== 8'd1 || st !== 3'd4) begin
         miscompares++;
         $display("FAIL async rematch: y=%b cnt=%0d st=%0d expected 1/1/4", y, cnt, st);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      overlap = 1'b1;
      apply_bit(1'b1, 1'b0);
      apply_bit(1'b0, 1'b0);
      apply_bit(1'b1, 1'b0);
      apply_bit(1'b1, 1'b0);
      for (int m = 2; m <= 5; m++) begin
         apply_bit(1'b0, 1'b0);
         apply_bit(1'b1, 1'b0);
         apply_bit(1'b1, 1'b0);
         vectors++;
         if (cnt2 !== 2'((m > 3) ? 3 : m) || cnt !== 8'(m) || y2 !== 1'b1) begin
            miscompares++;
            $display("FAIL saturate match%0d: cnt2=%0d cnt=%0d y2=%b expected %0d/%0d/1",
                     m, cnt2, cnt, y2, (m > 3) ? 3 : m, m);
         end
      end
      apply_bit(1'b0, 1'b0);
      apply_bit(1'b1, 1'b0);
      apply_bit(1'b1, 1'b1);
      vectors++;
      if (cnt2 !== 2'd0 || cnt !== 8'd0 || y2 !== 1'b1) begin
         miscompares++;
         $display("FAIL clear priority: cnt2=%0d cnt=%0d y2=%b expected 0/0/1", cnt2, cnt, y2);
      end
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_fallback();
      test_enable();
      test_async_reset();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
